cgol_rowmem: RTL and testbench
==============================

CGOL_ROWMEM -- requirements
Module: cgol_rowmem

Interface
REQ-001 Parameter WIDTH, default 8: bits per board row; all data ports are WIDTH wide.
REQ-002 Depth SHALL be fixed at 8 rows per bank, addressed by addr[2:0]; this is not parameterised.
REQ-003 ph1  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 addr  input  3  row address from the generation controller.
REQ-006 RWSelect  input  1  1 = read access, 0 = write access.
REQ-007 en  input  1  access strobe; an access is qualified only when en=1.
REQ-008 wdata  input  WIDTH  next-generation row data for write accesses.
REQ-009 load  input  1  initial-pattern load strobe; writes the current bank at addr.
REQ-010 ldata  input  WIDTH  initial-pattern row data.
REQ-011 swap  input  1  end-of-generation strobe; exchanges the current and next banks.
REQ-012 rdata  output  WIDTH  registered read data.
REQ-013 rvalid  output  1  rdata valid, one-cycle pulse per qualified read.
REQ-014 bank  output  1  index of the bank currently acting as "current" (the read bank).
REQ-015 gen  output  8  generation counter.

Function
REQ-016 Storage SHALL be two banks of 8 x WIDTH: mem[bank] is current (read, load), mem[~bank] is next (write).
REQ-017 Read: en=1, RWSelect=1, load=0 in cycle N -> rdata = mem[bank][addr] and rvalid=1 in cycle N+1 (latency 1).
REQ-018 In cycles following no qualified read, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-019 Write: en=1, RWSelect=0, load=0 -> mem[~bank][addr] <= wdata at the clock edge; no output change.
REQ-020 Load: load=1 -> mem[bank][addr] <= ldata; load SHALL take priority over en, and the en access in that cycle SHALL be discarded (no write, rvalid=0 next cycle).
REQ-021 Swap: swap=1 -> bank <= ~bank and gen <= gen+1, modulo 256 (255 wraps to 0).
REQ-022 Swap with a read in the same cycle: the read SHALL use the pre-swap bank.
REQ-023 Swap with a write in the same cycle: the write SHALL land in the pre-swap next bank, which is the new current bank after the edge.
REQ-024 Swap with a load in the same cycle: the load SHALL land in the pre-swap current bank; gen still increments.
REQ-025 Swap takes effect even when en=0 and load=0.
REQ-026 Writes and loads SHALL NOT alter rdata or rvalid.
REQ-027 There is no address hazard: reads and writes always target different banks, so no forwarding is required.
REQ-028 Unqualified cycles (en=0, load=0, swap=0) SHALL leave all state unchanged.

Reset
REQ-029 reset=1 at a clock edge SHALL clear both banks to 0 and set rdata=0, rvalid=0, bank=0, gen=0.
REQ-030 reset SHALL override every other input in the same cycle, including mid-generation; no access, load or swap is performed.
REQ-031 After reset deasserts, the first qualified read SHALL return 0.

Verification
REQ-032 Load rows 0..7 with 8'h01..8'h08, then read addr 3 -> next cycle rdata=8'h04, rvalid=1; following idle cycle rvalid=0, rdata=8'h04.
REQ-033 Write addr 5 = 8'hAA, read addr 5 -> old current value (8'h06); assert swap, read addr 5 -> 8'hAA, bank=1, gen=1.
REQ-034 Write addr 2 = 8'h55 with swap in the same cycle, then read addr 2 -> 8'h55. Read addr 2 with swap in the same cycle -> pre-swap value.
REQ-035 Load=1 with en=1, RWSelect=1 at addr 0 -> mem[bank][0] updated, rvalid=0 next cycle.
REQ-036 Apply 256 swaps -> gen wraps to 0 and bank returns to its start value.
REQ-037 Assert reset mid-sequence after data is loaded -> all outputs 0 next cycle; reads of every addr in both banks (across one swap) return 0.

Source files
------------

// File: rtl/cgol_rowmem_if.sv
// Access, load and swap bus between the generation controller and the two-bank row memory.
// The master drives requests; the slave returns read data and bank/generation status.
interface cgol_rowmem_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       addr;
    logic             RWSelect;
    logic             en;
    logic [WIDTH-1:0] wdata;
    logic             load;
    logic [WIDTH-1:0] ldata;
    logic             swap;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             bank;
    logic [7:0]       gen;

    modport master (
        output addr, RWSelect, en, wdata, load, ldata, swap,
        input  rdata, rvalid, bank, gen
    );

    modport slave (
        input  addr, RWSelect, en, wdata, load, ldata, swap,
        output rdata, rvalid, bank, gen
    );
endinterface

// File: rtl/cgol_rowmem.sv
// Double-buffered Game-of-Life row store: reads and loads use the current bank,
// writes fill the next bank, and swap exchanges the two while counting generations.
module cgol_rowmem #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               ph1,
    input  logic               reset,
    cgol_rowmem_if.slave       bus
);
    logic [WIDTH-1:0] mem_q [2][8];
    logic [WIDTH-1:0] mem_d [2][8];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             bank_q, bank_d;
    logic [7:0]       gen_q, gen_d;

    logic             next_bank;
    logic             rd_access;
    logic             wr_access;

    assign next_bank = ~bank_q;
    // Load wins over any en access in the same cycle; that access is dropped.
    assign rd_access = bus.en & bus.RWSelect & ~bus.load;
    assign wr_access = bus.en & ~bus.RWSelect & ~bus.load;

    always_comb begin
        mem_d    = mem_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        bank_d   = bank_q;
        gen_d    = gen_q;

        if (bus.load) begin
            mem_d[bank_q][bus.addr] = bus.ldata;
        end
        if (wr_access) begin
            mem_d[next_bank][bus.addr] = bus.wdata;
        end
        if (rd_access) begin
            rdata_d  = mem_q[bank_q][bus.addr];
            rvalid_d = 1'b1;
        end

        // Bank indices above are pre-swap, so same-cycle accesses see the old roles.
        if (bus.swap) begin
            bank_d = next_bank;
            gen_d  = gen_q + 8'd1;
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            bank_q   <= 1'b0;
            gen_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            bank_q   <= bank_d;
            gen_q    <= gen_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.bank   = bank_q;
    assign bus.gen    = gen_q;
endmodule

// File: tb/tb_cgol_rowmem.sv
// Scoreboarded bench for cgol_rowmem: a board-level model (current/next arrays exchanged
// on swap) predicts reads into a queue that an independent monitor drains.
module tb_cgol_rowmem;
    localparam int unsigned W = 8;

    logic ph1 = 1'b0;
    logic reset;

    cgol_rowmem_if #(.WIDTH(W)) bus ();

    cgol_rowmem #(.WIDTH(W)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ph1 = ~ph1;

    logic [W-1:0] cur [8];
    logic [W-1:0] nxt [8];
    int unsigned  swaps;
    logic         exp_rvalid;
    logic [W-1:0] exp_hold;
    logic [W-1:0] expq [$];

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          done  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] a, input logic rw, input logic e,
                        input logic [W-1:0] wd, input logic ld, input logic [W-1:0] ldd,
                        input logic sw);
        logic [W-1:0] t;
        reset        = rst;
        bus.addr     = a;
        bus.RWSelect = rw;
        bus.en       = e;
        bus.wdata    = wd;
        bus.load     = ld;
        bus.ldata    = ldd;
        bus.swap     = sw;
        @(posedge ph1);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                cur[i] = '0;
                nxt[i] = '0;
            end
            swaps      = 0;
            exp_rvalid = 1'b0;
            exp_hold   = '0;
            expq.delete();
        end else begin
            exp_rvalid = 1'b0;
            if (ld) begin
                cur[a] = ldd;
            end else if (e && rw) begin
                exp_rvalid = 1'b1;
                exp_hold   = cur[a];
                expq.push_back(cur[a]);
            end else if (e) begin
                nxt[a] = wd;
            end
            if (sw) begin
                for (int i = 0; i < 8; i++) begin
                    t      = cur[i];
                    cur[i] = nxt[i];
                    nxt[i] = t;
                end
                swaps++;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, input logic sw);
        step(1'b0, a, 1'b1, 1'b1, '0, 1'b0, '0, sw);
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d, input logic sw);
        step(1'b0, a, 1'b0, 1'b1, d, 1'b0, '0, sw);
    endtask

    task automatic ldrow(input logic [2:0] a, input logic [W-1:0] d);
        step(1'b0, a, 1'b0, 1'b0, '0, 1'b1, d, 1'b0);
    endtask

    // Monitor: status every cycle, read data popped from the scoreboard on rvalid.
    initial begin
        logic [W-1:0] e;
        @(posedge ph1);
        forever begin
            @(negedge ph1);
            if (done) break;
            chk("bank", {31'd0, bus.bank}, {31'd0, swaps[0]});
            chk("gen", {24'd0, bus.gen}, {24'd0, swaps[7:0]});
            chk("rvalid", {31'd0, bus.rvalid}, {31'd0, exp_rvalid});
            if (bus.rvalid) begin
                if (expq.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rdata", {24'd0, bus.rdata}, {24'd0, e});
                end
            end else begin
                if (exp_rvalid && expq.size() != 0) void'(expq.pop_front());
                chk("rdata_hold", {24'd0, bus.rdata}, {24'd0, exp_hold});
            end
        end
    end

    initial begin
        logic [W-1:0] ld_val;
        step(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        rd(3'd6, 1'b0);
        idle();

        for (int i = 0; i < 8; i++) begin
            ld_val = W'(i + 1);
            ldrow(3'(i), ld_val);
        end
        rd(3'd3, 1'b0);
        idle();
        idle();

        wr(3'd5, 8'hAA, 1'b0);
        rd(3'd5, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        rd(3'd5, 1'b0);
        idle();

        wr(3'd2, 8'h55, 1'b1);
        rd(3'd2, 1'b0);
        rd(3'd2, 1'b1);
        rd(3'd2, 1'b0);

        step(1'b0, 3'd0, 1'b1, 1'b1, '0, 1'b1, 8'h77, 1'b0);
        rd(3'd0, 1'b0);
        step(1'b0, 3'd1, 1'b0, 1'b1, 8'h99, 1'b1, 8'h3C, 1'b1);
        rd(3'd1, 1'b0);

        for (int i = 0; i < 256; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        end
        idle();

        for (int i = 0; i < 8; i++) wr(3'(i), 8'hF0 | W'(i), 1'b0);
        step(1'b1, 3'd4, 1'b1, 1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
        for (int i = 0; i < 8; i++) rd(3'(i), 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) rd(3'(i), 1'b0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 W'($urandom),
                 ($urandom_range(0, 5) == 0),
                 W'($urandom),
                 ($urandom_range(0, 6) == 0));
        end
        idle();
        idle();

        done = 1'b1;
        @(negedge ph1);
        chk("queue_drained", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
